sram_march_bist: RTL and testbench
==================================

# sram_march_bist

March C- built-in self-test engine that drives the single-port `RW0_*` interface of the cache SRAM wrappers (D-cache data/tag, I-cache data/tag). It is the initiator for that port, the opposite end from the macro wrappers. It writes and reads back every address, compares the read data one cycle after each read, and reports pass/fail with the first failing location. A system-level mux elsewhere selects between this engine and the cache pipeline.

## Interface

Parameters:
- `ADDR_W`, 10, address width; depth D = 2^ADDR_W, power of two only.
- `DATA_W`, 32, data width.
- `MASK_W`, 4, write-mask width; driven all-ones during test.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled in IDLE or DONE only.
- `busy`  out  1  test in progress (RUN or DRAIN).
- `done`  out  1  test finished; held until next `start` or `reset`.
- `fail`  out  1  sticky miscompare flag; meaningful when `done`=1.
- `fail_addr`  out  ADDR_W  address of the first miscompare.
- `fail_elem`  out  3  March element (0–5) of the first miscompare.
- `fail_syndrome`  out  DATA_W  expected XOR actual at the first miscompare.
- `RW0_addr`  out  ADDR_W  SRAM address.
- `RW0_en`  out  1  access enable.
- `RW0_wmode`  out  1  1 = write, 0 = read.
- `RW0_wmask`  out  MASK_W  all-ones when writing, zero otherwise.
- `RW0_wdata`  out  DATA_W  write data, all-zeros or all-ones background.
- `RW0_rdata`  in  DATA_W  read data, valid the cycle after a read with `RW0_en`=1.

## Operation

- Sequence of March elements, with address order and operations:
  - M0 ↑ w0
  - M1 ↑ (r0, w1)
  - M2 ↑ (r1, w0)
  - M3 ↓ (r0, w1)
  - M4 ↓ (r1, w0)
  - M5 ↑ r0
- Background encoding: "0" = {DATA_W{1'b0}}, "1" = {DATA_W{1'b1}}.
- One operation is issued per cycle. For two-operation elements, the read goes in cycle t and the write to the same address in cycle t+1; then the address advances.
- Address order:
  - ↑ runs 0 → D−1.
  - ↓ runs D−1 → 0.
  - The element advances after the terminal address. No wrap-around occurs inside an element.
- States:
  - IDLE: `start` → RUN; counters cleared; fail fields cleared.
  - RUN: issue operations. After the last M5 read → DRAIN.
  - DRAIN: compare the final read → DONE.
  - DONE: `start` → RUN, with the same clearing as from IDLE.
- `start` is ignored in RUN and DRAIN.
- Compare: a registered expect-valid flag, the expected background, element and address from cycle t are checked against `RW0_rdata` in cycle t+1.
  - On mismatch with `fail`=0: set `fail` and capture `fail_addr`, `fail_elem`, `fail_syndrome`.
  - Later mismatches do not overwrite the captured fields.
- Reset values: `busy`=0, `done`=0, `fail`=0, all `fail_*`=0, `RW0_en`=0, `RW0_wmode`=0, `RW0_wmask`=0, `RW0_addr`=0, `RW0_wdata`=0; state IDLE.
- Reset mid-test aborts immediately. Outputs take reset values and no further SRAM access is issued.
- `RW0_en`=0 in IDLE, DRAIN and DONE.

## Timing

- `start` is sampled at cycle 0; the first access is at cycle 1.
- Accesses occupy cycles 1 … 10·D: M0 and M5 take D cycles each, M1–M4 take 2·D each.
- DRAIN is at cycle 10·D+1.
- `done`=1 from cycle 10·D+2. `busy`=1 during cycles 1 … 10·D+1.
- All outputs are registered. There is no combinational path from `RW0_rdata` to any output.

## Structure

- Package `marmot_bist_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE)
  - element index type (3 bits)
  - per-element constant tables: direction, op count, read background, write background
- Sub-module `sram_bist_addr_gen`: up/down address counter with load-to-first and terminal-count outputs, driven by element direction.

## Test plan

Bench: ADDR_W=4 (D=16), DATA_W=32, behavioral 1-cycle-latency memory model with fault injection.

- Clean memory, `start` at cycle 0 → `busy` during cycles 1–161, `done`=1 at cycle 162, `fail`=0; exactly 160 cycles with `RW0_en`=1.
- Bit 5 of address 3 stuck-at-1 → `fail`=1, `fail_elem`=1, `fail_addr`=3, `fail_syndrome`=0x00000020.
- Bit 0 of address 15 stuck-at-0 → first capture is `fail_elem`=2, `fail_addr`=15, `fail_syndrome`=0x00000001; later mismatches leave the fields unchanged.
- Address monitor during M3 sees 15,14,…,0, and M4 follows starting at 15 with no gap cycle.
- `reset` asserted at cycle 50 → same cycle `RW0_en`=0 and `busy`=0; after release, stays IDLE and no access occurs until `start`.
- After a failing run in DONE, `start` on a clean memory → `fail` cleared at cycle 1, `done`=0 until cycle 162, final `fail`=0; `start` pulsed in RUN is ignored.

Source files
------------

// File: rtl/marmot_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST engine.
// Element e is described by bit e of each table; bits 6 and 7 are unused padding.
package marmot_bist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} bist_state_e;

  typedef logic [2:0] elem_t;

  localparam elem_t LastElem = 3'd5;

  // M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 | M5 up r0
  localparam logic [7:0] ElemDown    = 8'b0001_1000;
  localparam logic [7:0] ElemTwoOp   = 8'b0001_1110;
  localparam logic [7:0] ElemHasRead = 8'b0011_1110;
  localparam logic [7:0] ElemRdBg    = 8'b0001_0100;
  localparam logic [7:0] ElemWrBg    = 8'b0000_1010;

  // Phase 1 is always the write of a two-operation element.
  function automatic logic op_is_write(elem_t e, logic phase);
    return phase | ~ElemHasRead[e];
  endfunction

  function automatic logic op_bg(elem_t e, logic phase);
    return op_is_write(e, phase) ? ElemWrBg[e] : ElemRdBg[e];
  endfunction

endpackage

// File: rtl/sram_march_bist_if.sv
// Single-port RW0 SRAM access bundle; the BIST engine is the master.
interface sram_march_bist_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 4
);
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_rdata
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_rdata
  );
endinterface

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter; direction is latched on load and governs stepping
// and the terminal-count flag until the next load.
module sram_bist_addr_gen #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic              r_down;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_down <= i_load_down;
      r_addr <= i_load_down ? '1 : '0;
    end else if (i_step) begin
      r_addr <= r_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = r_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator for the cache SRAM RW0 port; reports the first
// miscompare (address, element, syndrome) once the run completes.
module sram_march_bist
  import marmot_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [ADDR_W-1:0]   fail_addr,
  output elem_t               fail_elem,
  output logic [DATA_W-1:0]   fail_syndrome,
  sram_march_bist_if.master   rw0
);

  bist_state_e r_state, w_state_nxt;
  elem_t       r_elem, w_elem_nxt;
  logic        r_phase, w_phase_nxt;

  logic              r_en, r_wmode;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy, r_done;

  logic              r_fail;
  logic [ADDR_W-1:0] r_fail_addr;
  elem_t             r_fail_elem;
  logic [DATA_W-1:0] r_fail_syn;

  logic              r_exp_vld, r_exp_bg;
  elem_t             r_exp_elem;
  logic [ADDR_W-1:0] r_exp_addr;

  logic              w_load, w_load_down, w_step, w_issue, w_issue_wr, w_issue_bg, w_clear;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic [DATA_W-1:0] w_syndrome;
  logic              w_mismatch;

  // The counter register doubles as the registered RW0 address.
  sram_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_elem  <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_load_down = 1'b0;
    w_step      = 1'b0;
    w_issue     = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StRun;
          w_elem_nxt  = '0;
          w_phase_nxt = 1'b0;
          w_load      = 1'b1;
          w_load_down = ElemDown[0];
          w_issue     = 1'b1;
          w_clear     = 1'b1;
        end
      end
      StRun: begin
        if (ElemTwoOp[r_elem] && !r_phase) begin
          w_phase_nxt = 1'b1;
          w_issue     = 1'b1;
        end else if (!w_last) begin
          w_phase_nxt = 1'b0;
          w_step      = 1'b1;
          w_issue     = 1'b1;
        end else if (r_elem == LastElem) begin
          w_phase_nxt = 1'b0;
          w_state_nxt = StDrain;
        end else begin
          w_elem_nxt  = r_elem + elem_t'(1);
          w_phase_nxt = 1'b0;
          w_load      = 1'b1;
          w_load_down = ElemDown[w_elem_nxt];
          w_issue     = 1'b1;
        end
      end
      StDrain: w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
    w_issue_wr = op_is_write(w_elem_nxt, w_phase_nxt);
    w_issue_bg = op_bg(w_elem_nxt, w_phase_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_wmode <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_en    <= w_issue;
      r_wmode <= w_issue & w_issue_wr;
      r_wmask <= (w_issue && w_issue_wr) ? '1 : '0;
      r_wdata <= (w_issue && w_issue_wr && w_issue_bg) ? '1 : '0;
      r_busy  <= (w_state_nxt == StRun) || (w_state_nxt == StDrain);
      r_done  <= (w_state_nxt == StDone);
    end
  end

  // Read data lags the read by one cycle, so the expectation is pipelined alongside it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_exp_vld  <= 1'b0;
      r_exp_bg   <= 1'b0;
      r_exp_elem <= '0;
      r_exp_addr <= '0;
    end else begin
      r_exp_vld  <= r_en & ~r_wmode;
      r_exp_bg   <= ElemRdBg[r_elem];
      r_exp_elem <= r_elem;
      r_exp_addr <= w_addr;
    end
  end

  assign w_syndrome = {DATA_W{r_exp_bg}} ^ rw0.RW0_rdata;
  assign w_mismatch = r_exp_vld && (|w_syndrome);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_syn  <= '0;
    end else if (w_clear) begin
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_fail_syn  <= '0;
    end else if (w_mismatch && !r_fail) begin
      r_fail      <= 1'b1;
      r_fail_addr <= r_exp_addr;
      r_fail_elem <= r_exp_elem;
      r_fail_syn  <= w_syndrome;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;
  assign fail_addr     = r_fail_addr;
  assign fail_elem     = r_fail_elem;
  assign fail_syndrome = r_fail_syn;

  assign rw0.RW0_addr  = w_addr;
  assign rw0.RW0_en    = r_en;
  assign rw0.RW0_wmode = r_wmode;
  assign rw0.RW0_wmask = r_wmask;
  assign rw0.RW0_wdata = r_wdata;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: faulty 1-cycle SRAM model, March C- reference model,
// access and result scoreboards.
module tb_sram_march_bist;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned D  = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct packed {
    logic          fl;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    logic [DW-1:0] syn;
  } res_t;

  logic clock = 1'b0;
  logic reset, start;
  logic busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syndrome;

  sram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) rw0 ();

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_elem     (fail_elem),
    .fail_syndrome (fail_syndrome),
    .rw0           (rw0)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SRAM model with one stuck-at location
  logic [DW-1:0] mem [D];
  int            flt_addr = -1;
  logic [DW-1:0] sa1 = '0;
  logic [DW-1:0] sa0 = '0;

  function automatic logic [DW-1:0] faulty(int a, logic [DW-1:0] v);
    return (a == flt_addr) ? ((v | sa1) & ~sa0) : v;
  endfunction

  always @(posedge clock) begin
    if (rw0.RW0_en) begin
      if (rw0.RW0_wmode) mem[rw0.RW0_addr] <= faulty(int'(rw0.RW0_addr), rw0.RW0_wdata);
      else               rw0.RW0_rdata <= mem[rw0.RW0_addr];
    end
  end

  acc_t acc_q[$];
  res_t res_q[$];

  function automatic acc_t mk_acc(int a, bit wr, logic [DW-1:0] d);
    acc_t x;
    x.addr = a[AW-1:0];
    x.wr   = wr;
    x.data = d;
    return x;
  endfunction

  // March C- walked directly from its notation over an array memory.
  task automatic model_run();
    logic [DW-1:0] m [D];
    res_t          r;
    bit            down;
    int            a;
    logic [DW-1:0] want, val;
    r = '0;
    for (int e = 0; e < 6; e++) begin
      down = (e == 3) || (e == 4);
      for (int i = 0; i < D; i++) begin
        a = down ? D - 1 - i : i;
        if (e != 0) begin
          want = (e == 2 || e == 4) ? '1 : '0;
          acc_q.push_back(mk_acc(a, 1'b0, '0));
          if (m[a] !== want && !r.fl) begin
            r.fl   = 1'b1;
            r.addr = a[AW-1:0];
            r.elem = e[2:0];
            r.syn  = m[a] ^ want;
          end
        end
        if (e != 5) begin
          val = (e == 1 || e == 3) ? '1 : '0;
          acc_q.push_back(mk_acc(a, 1'b1, val));
          m[a] = faulty(a, val);
        end
      end
    end
    res_q.push_back(r);
  endtask

  int unsigned edge_cnt = 0;
  int unsigned s_cyc = 0;
  int          acc_cnt = 0;
  int          busy_cnt = 0;
  int          en_cnt = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    acc_t e;
    if (busy) busy_cnt++;
    if (rw0.RW0_en) begin
      acc_cnt++;
      en_cnt++;
      if (acc_q.size() == 0) begin
        chk("unexpected_access", {rw0.RW0_addr, rw0.RW0_wmode}, 0);
      end else begin
        e = acc_q.pop_front();
        chk("access", {rw0.RW0_addr, rw0.RW0_wmode, rw0.RW0_wmask, rw0.RW0_wdata},
            {e.addr, e.wr, (e.wr ? 4'hf : 4'h0), e.data});
      end
    end
  end

  logic prev_done = 1'b0;
  always @(negedge clock) begin
    res_t r;
    if (done && !prev_done) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", edge_cnt - s_cyc, 0);
      end else begin
        r = res_q.pop_front();
        chk("done_cycle", edge_cnt - s_cyc, 10 * D + 2);
        chk("access_count", acc_cnt, 10 * D);
        chk("busy_cycles", busy_cnt, 10 * D + 1);
        chk("busy_at_done", busy, 0);
        chk("fail", fail, r.fl);
        chk("fail_addr", fail_addr, r.addr);
        chk("fail_elem", fail_elem, r.elem);
        chk("fail_syndrome", fail_syndrome, r.syn);
      end
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_fault(input int a, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
    flt_addr = a;
    sa1      = s1;
    sa0      = s0;
  endtask

  // Returns at the negedge of cycle 1.
  task automatic launch();
    @(negedge clock);
    model_run();
    acc_cnt  = 0;
    busy_cnt = 0;
    s_cyc    = edge_cnt;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (res_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("result_pending", res_q.size(), 0);
    chk("accesses_left", acc_q.size(), 0);
    res_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int snap, a, b;
    reset = 1'b1;
    start = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_elem", fail_elem, 0);
    chk("rst_fail_syn", fail_syndrome, 0);
    chk("rst_en", rw0.RW0_en, 0);
    chk("rst_wmode", rw0.RW0_wmode, 0);
    chk("rst_wmask", rw0.RW0_wmask, 0);
    chk("rst_addr", rw0.RW0_addr, 0);
    chk("rst_wdata", rw0.RW0_wdata, 0);
    @(negedge clock);
    reset = 1'b0;
    tick(2);

    // Clean memory
    set_fault(-1, '0, '0);
    launch();
    wait_result();

    // Stuck-at-1 on bit 5 of address 3
    set_fault(3, 32'h0000_0020, '0);
    launch();
    wait_result();
    chk("sa1_fail", fail, 1);
    chk("sa1_elem", fail_elem, 1);
    chk("sa1_addr", fail_addr, 3);
    chk("sa1_syn", fail_syndrome, 32'h0000_0020);

    // Stuck-at-0 on bit 0 of address 15; later M4 miscompare must not overwrite
    set_fault(15, '0, 32'h0000_0001);
    launch();
    wait_result();
    chk("sa0_fail", fail, 1);
    chk("sa0_elem", fail_elem, 2);
    chk("sa0_addr", fail_addr, 15);
    chk("sa0_syn", fail_syndrome, 32'h0000_0001);

    // Restart from a failing DONE on clean memory, with a start pulse mid-run
    set_fault(-1, '0, '0);
    launch();
    chk("restart_fail_c1", fail, 0);
    chk("restart_done_c1", done, 0);
    tick(79);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_result();

    // Reset in cycle 50 aborts; nothing happens until the next start
    launch();
    tick(49);
    #2 reset = 1'b1;
    #1;
    chk("abort_en", rw0.RW0_en, 0);
    chk("abort_busy", busy, 0);
    acc_q.delete();
    res_q.delete();
    @(negedge clock);
    reset = 1'b0;
    snap = en_cnt;
    tick(20);
    chk("idle_no_access", en_cnt - snap, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Randomised single stuck-at faults
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, D - 1);
      b = $urandom_range(0, DW - 1);
      if ($urandom_range(0, 1) == 1) set_fault(a, 32'(1) << b, '0);
      else                           set_fault(a, '0, 32'(1) << b);
      tick($urandom_range(0, 5));
      launch();
      wait_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
